// File: rtl/ipsl_pcie_sync_pkg.sv
// Shared limits, filter FSM state encoding and parameter legality check for the sync bus.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ipsl_pcie_sync_pkg;

    localparam int CH_MAX     = 32;
    localparam int STAGES_MIN = 2;
    localparam int STAGES_MAX = 4;
    localparam int FILT_MAX   = 255;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } filt_state_t;

    function automatic bit params_legal(int ch, int stages, int filt);
        return (ch >= 1) && (ch <= CH_MAX) &&
               (stages >= STAGES_MIN) && (stages <= STAGES_MAX) &&
               (filt >= 0) && (filt <= FILT_MAX);
    endfunction

endpackage

// File: rtl/ipsl_pcie_sync_ch_v1_1.sv
// Single-channel synchroniser chain, optional glitch filter and edge detector.
// Latency: STAGES cycles unfiltered; filtered adds FILT_CYC+1 FSM cycles after chain_out settles.
// Backpressure: none; a level input sampled every clk, pulses last exactly one cycle.
module ipsl_pcie_sync_ch_v1_1
    import ipsl_pcie_sync_pkg::*;
#(
    parameter int   STAGES   = 2,
    parameter int   FILT_CYC = 0,
    parameter logic RST_VAL  = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_async,
    output logic sig_synced,
    output logic sig_rise,
    output logic sig_fall
);

    (* async_reg = "true" *) logic chain [STAGES];
    logic chain_out;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) chain[k] <= RST_VAL;
        end else begin
            chain[0] <= sig_async;
            for (int k = 1; k < STAGES; k++) chain[k] <= chain[k-1];
        end
    end

    assign chain_out = chain[STAGES-1];

    if (FILT_CYC == 0) begin : g_nofilt
        assign sig_synced = chain_out;
    end else begin : g_filt
        localparam int CW = $clog2(FILT_CYC + 1);

        filt_state_t   state;
        logic [CW-1:0] cnt;
        logic          synced_q;

        // cnt counts consecutive mismatching cycles; it saturates at FILT_CYC by construction
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state    <= ST_STABLE;
                cnt      <= '0;
                synced_q <= RST_VAL;
            end else begin
                case (state)
                    ST_STABLE: begin
                        if (chain_out != synced_q) begin
                            state <= ST_PENDING;
                            cnt   <= CW'(1);
                        end else begin
                            cnt <= '0;
                        end
                    end
                    ST_PENDING: begin
                        if (chain_out == synced_q) begin
                            state <= ST_STABLE;
                            cnt   <= '0;
                        end else if (cnt == CW'(FILT_CYC)) begin
                            synced_q <= chain_out;
                            state    <= ST_STABLE;
                            cnt      <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        state <= ST_STABLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end

        assign sig_synced = synced_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= RST_VAL;
        else        prev <= sig_synced;
    end

    assign sig_rise = sig_synced & ~prev;
    assign sig_fall = ~sig_synced & prev;

    a_no_rise_and_fall: assert property (@(posedge clk) disable iff (!rst_n) !(sig_rise && sig_fall));

endmodule

// File: rtl/ipsl_pcie_sync_bus_v1_1.sv
// CH-wide bus of independent synchronisers with glitch filter and rise/fall detection.
// Latency: per channel, see ipsl_pcie_sync_ch_v1_1; chg_any is combinational from the pulses.
// Backpressure: none; every channel samples its level input every clk.
module ipsl_pcie_sync_bus_v1_1
    import ipsl_pcie_sync_pkg::*;
#(
    parameter int          CH       = 1,
    parameter int          STAGES   = 2,
    parameter int          FILT_CYC = 0,
    parameter logic [CH-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] sig_async,
    output logic [CH-1:0] sig_synced,
    output logic [CH-1:0] sig_rise,
    output logic [CH-1:0] sig_fall,
    output logic          chg_any
);

    if (!params_legal(CH, STAGES, FILT_CYC)) begin : g_bad_param
        $error("ipsl_pcie_sync_bus_v1_1: CH, STAGES or FILT_CYC out of range");
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        ipsl_pcie_sync_ch_v1_1 #(
            .STAGES   (STAGES),
            .FILT_CYC (FILT_CYC),
            .RST_VAL  (RST_VAL[i])
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .sig_async  (sig_async[i]),
            .sig_synced (sig_synced[i]),
            .sig_rise   (sig_rise[i]),
            .sig_fall   (sig_fall[i])
        );
    end

    assign chg_any = |(sig_rise | sig_fall);

endmodule
